// File: rtl/mem_stage.sv
// Memory pipeline stage: word RAM with fixed-latency loads, single-cycle
// write-back for ALU results and stores, and a misalignment fault pulse.
module mem_stage #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned DEPTH   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] F,
  input  logic [31:0] store_data,
  input  logic [3:0]  W_Addr,
  input  logic        Write_Reg,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [3:0]  wb_addr,
  output logic        wb_write_reg,
  output logic        misalign
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 3;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] ld_addr_q, ld_addr_d;
  logic [3:0]    ld_reg_q, ld_reg_d;
  logic          ld_we_q, ld_we_d;
  logic          wb_valid_q, wb_valid_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [3:0]    wb_addr_q, wb_addr_d;
  logic          wb_write_reg_q, wb_write_reg_d;
  logic          misalign_q, misalign_d;

  logic [31:0]   ram_q [DEPTH];
  logic          ram_we;
  logic [AW-1:0] ram_waddr;

  logic          is_mem;
  logic          is_misaligned;

  assign is_mem        = mem_read | mem_write;
  assign is_misaligned = is_mem && (F[1:0] != 2'b00);

  // Next-state, counter and write-back computation
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ld_addr_d      = ld_addr_q;
    ld_reg_d       = ld_reg_q;
    ld_we_d        = ld_we_q;
    wb_valid_d     = 1'b0;
    wb_data_d      = wb_data_q;
    wb_addr_d      = wb_addr_q;
    wb_write_reg_d = 1'b0;
    misalign_d     = 1'b0;
    ram_we         = 1'b0;
    ram_waddr      = F[2 +: AW];

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (is_misaligned) begin
            misalign_d = 1'b1;
            wb_valid_d = 1'b1;
          end else if (mem_read) begin
            // A simultaneous read+write request is handled as a plain load
            ld_addr_d = F[2 +: AW];
            ld_reg_d  = W_Addr;
            ld_we_d   = Write_Reg;
            cnt_d     = CW'(MEM_LAT - 1);
            state_d   = WAIT;
          end else if (mem_write) begin
            ram_we     = 1'b1;
            wb_valid_d = 1'b1;
          end else begin
            wb_valid_d     = 1'b1;
            wb_data_d      = F;
            wb_addr_d      = W_Addr;
            wb_write_reg_d = Write_Reg;
          end
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          wb_valid_d     = 1'b1;
          wb_data_d      = ram_q[ld_addr_q];
          wb_addr_d      = ld_reg_q;
          wb_write_reg_d = ld_we_q;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and write-back registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      ld_addr_q      <= '0;
      ld_reg_q       <= '0;
      ld_we_q        <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= '0;
      wb_addr_q      <= '0;
      wb_write_reg_q <= 1'b0;
      misalign_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ld_addr_q      <= ld_addr_d;
      ld_reg_q       <= ld_reg_d;
      ld_we_q        <= ld_we_d;
      wb_valid_q     <= wb_valid_d;
      wb_data_q      <= wb_data_d;
      wb_addr_q      <= wb_addr_d;
      wb_write_reg_q <= wb_write_reg_d;
      misalign_q     <= misalign_d;
    end
  end

  // Data RAM keeps its contents across reset
  always_ff @(posedge clk) begin
    if (ram_we && !rst) begin
      ram_q[ram_waddr] <= store_data;
    end
  end

  assign stall        = (state_q == WAIT);
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_addr      = wb_addr_q;
  assign wb_write_reg = wb_write_reg_q;
  assign misalign     = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus random traffic checked
// against a transaction-level model of the stage.
module tb_mem_stage;

  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned DEPTH   = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, mem_read, mem_write, Write_Reg;
  logic [31:0] F, store_data;
  logic [3:0]  W_Addr;
  logic        stall, wb_valid, wb_write_reg, misalign;
  logic [31:0] wb_data;
  logic [3:0]  wb_addr;

  mem_stage #(.MEM_LAT(MEM_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_read(mem_read),
    .mem_write(mem_write), .F(F), .store_data(store_data), .W_Addr(W_Addr),
    .Write_Reg(Write_Reg), .stall(stall), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_addr(wb_addr), .wb_write_reg(wb_write_reg),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: memory image plus one outstanding-load record
  logic [31:0] mem [DEPTH];
  int          cyc = 0;
  bit          busy = 0;
  int          retire_at;
  int          ld_idx;
  logic [3:0]  ld_wa;
  logic        ld_wre;
  bit          known = 1;
  logic [31:0] exp_data = '0;
  logic [3:0]  exp_addr = '0;
  logic        e_wbv, e_mis, e_wre, e_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".stall"},    32'(stall),        32'(e_stall));
    chk({tag, ".wb_valid"}, 32'(wb_valid),     32'(e_wbv));
    chk({tag, ".misalign"}, 32'(misalign),     32'(e_mis));
    chk({tag, ".wb_wreg"},  32'(wb_write_reg), 32'(e_wre));
    if (known) begin
      chk({tag, ".wb_data"}, wb_data,       exp_data);
      chk({tag, ".wb_addr"}, 32'(wb_addr),  32'(exp_addr));
    end
  endtask

  // Drive one cycle of inputs, advance the model one edge, then check.
  task automatic step(input string tag, input logic v, input logic rd, input logic wr,
                      input logic [31:0] f, input logic [31:0] sd,
                      input logic [3:0] wa, input logic wre);
    valid_in = v; mem_read = rd; mem_write = wr; F = f; store_data = sd;
    W_Addr = wa; Write_Reg = wre;
    @(posedge clk);
    cyc++;
    e_wbv = 1'b0; e_mis = 1'b0; e_wre = 1'b0;
    if (busy) begin
      if (cyc == retire_at) begin
        busy = 0; e_wbv = 1'b1; e_wre = ld_wre;
        exp_data = mem[ld_idx]; exp_addr = ld_wa; known = 1;
      end
    end else if (v) begin
      if ((rd || wr) && f[1:0] != 2'b00) begin
        e_wbv = 1'b1; e_mis = 1'b1; known = 0;
      end else if (rd) begin
        busy = 1; retire_at = cyc + int'(MEM_LAT);
        ld_idx = int'(f[7:2]); ld_wa = wa; ld_wre = wre;
      end else if (wr) begin
        mem[int'(f[7:2])] = sd; e_wbv = 1'b1; known = 0;
      end else begin
        e_wbv = 1'b1; e_wre = wre; exp_data = f; exp_addr = wa; known = 1;
      end
    end
    e_stall = busy;
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  int stall_cnt;

  initial begin
    rst = 1'b1; valid_in = 0; mem_read = 0; mem_write = 0;
    F = '0; store_data = '0; W_Addr = '0; Write_Reg = 0;
    #12;
    e_stall = 0; e_wbv = 0; e_mis = 0; e_wre = 0; known = 1;
    exp_data = '0; exp_addr = '0;
    check_outputs("reset");
    @(negedge clk); rst = 1'b0;

    // First accept on the first edge after reset release
    step("alu5", 1'b1, 1'b0, 1'b0, 32'h5, 32'h0, 4'd3, 1'b1);
    idle("alu5_hold");

    for (int i = 0; i < int'(DEPTH); i++)
      step("fill", 1'b1, 1'b0, 1'b1, 32'(i * 4), $urandom, 4'($urandom), 1'b1);

    step("st10", 1'b1, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'd1, 1'b1);
    step("ld10", 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'd7, 1'b1);
    stall_cnt = 1;
    for (int i = 0; i < 10 && busy; i++) begin
      // Changed inputs while stalled must be ignored
      step("ld10_wait", 1'b1, 1'b0, 1'b0, $urandom, 32'h0, 4'($urandom), 1'b1);
      if (stall) stall_cnt++;
    end
    chk("ld10_stall_cycles", 32'(stall_cnt), 32'(MEM_LAT));
    chk("ld10_data", wb_data, 32'hDEAD_BEEF);
    step("after_ld", 1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 4'd2, 1'b1);

    step("mis13", 1'b1, 1'b1, 1'b0, 32'h13, 32'h0, 4'd4, 1'b1);
    step("mis_st", 1'b1, 1'b0, 1'b1, 32'h12, 32'h5555, 4'd4, 1'b1);
    step("rw_both", 1'b1, 1'b1, 1'b1, 32'h10, 32'hBAD0_BAD0, 4'd5, 1'b1);
    while (busy) idle("rw_wait");
    chk("rw_nowrite", wb_data, 32'hDEAD_BEEF);

    step("st104", 1'b1, 1'b0, 1'b1, 32'h104, 32'h1234, 4'd0, 1'b0);
    step("ld04", 1'b1, 1'b1, 1'b0, 32'h04, 32'h0, 4'd9, 1'b1);
    while (busy) idle("ld04_wait");
    chk("wrap_data", wb_data, 32'h1234);

    // Reset during an outstanding load aborts it; RAM survives
    step("ld20", 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'd6, 1'b1);
    valid_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    busy = 0; known = 1; exp_data = '0; exp_addr = '0;
    e_stall = 0; e_wbv = 0; e_mis = 0; e_wre = 0;
    check_outputs("rst_mid");
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) idle("post_rst");
    step("ld20b", 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'd6, 1'b1);
    while (busy) idle("ld20b_wait");

    for (int i = 0; i < 600; i++) begin
      int unsigned op;
      logic [31:0] f;
      op = $urandom_range(0, 9);
      f  = $urandom;
      if (op < 7 && $urandom_range(0, 5) != 0) f[1:0] = 2'b00;
      step("rand", 1'($urandom_range(0, 3) != 0), 1'(op < 3 || op == 9),
           1'((op >= 3 && op < 6) || op == 9), f, $urandom, 4'($urandom), 1'($urandom));
    end
    while (busy) idle("drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
